openframe_gpio_ctrl: RTL and testbench
======================================

Name: openframe_gpio_ctrl

Overview:
Memory-mapped GPIO pad controller inside picosoc, directly upstream of the openframe padframe GPIO outputs. It holds per-pad configuration and output registers and drives gpio_out, gpio_oe, gpio_ie, gpio_schmitt, gpio_slew, gpio_pullup, gpio_pulldown, gpio_drive0 and gpio_drive1. It synchronizes gpio_in for CPU readback and raises a level interrupt on enabled rising edges. It attaches to the picosoc iomem valid/ready bus.

Parameters:
NPADS, 44, number of GPIO pads (must be 33..64)
ADDR_W, 8, number of byte-address bits decoded (register offset)

Ports:
clk  input  1  system clock
resetb  input  1  asynchronous active-low reset
bus_valid  input  1  iomem request valid, held until bus_ready
bus_ready  output  1  one-cycle completion pulse
bus_wstrb  input  4  byte write strobes; 0 = read
bus_addr  input  ADDR_W  byte offset (bits 1:0 ignored)
bus_wdata  input  32  write data
bus_rdata  output  32  read data, valid while bus_ready=1
gpio_in  input  NPADS  raw pad input (asynchronous)
gpio_out, gpio_oe, gpio_ie, gpio_schmitt, gpio_slew, gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1  output  NPADS each  pad controls, direct register outputs
irq  output  1  OR of pending interrupt status

Behaviour:
- Single clock domain, clk; resetb is asynchronous assert, active-low; all flops are reset by it.
- Register map: word pairs, LO = pads 31:0, HI = pads NPADS-1:32 in the low bits. HI upper bits read 0 and ignore writes.
- 0x00/04 OUT; 0x08/0C OE; 0x10/14 IE; 0x18/1C SCHMITT; 0x20/24 SLEW; 0x28/2C PULLUP; 0x30/34 PULLDOWN; 0x38/3C DRIVE0; 0x40/44 DRIVE1.
- 0x48/4C IN: read-only synchronized input; writes are ignored.
- 0x50/54 IRQ_EN: read/write.
- 0x58/5C IRQ_STAT: write-1-to-clear.
- Reset values: IE all ones (pads default to input); every other register 0. Outputs: gpio_oe=0, gpio_out=0, gpio_ie=all 1, all others 0, bus_ready=0, bus_rdata=0, irq=0.
- Handshake:
  - When bus_valid=1 and bus_ready=0, bus_ready=1 on the next cycle for exactly one cycle, so latency is 1 cycle.
  - The write takes effect on that edge under byte strobes.
  - bus_rdata is registered with bus_ready and is 0 when bus_ready=0.
  - Back-to-back requests complete every second cycle.
  - bus_valid dropping before ready is illegal; the response is undefined but must not corrupt unaddressed registers.
- Unmapped offsets (>=0x60): read 0, write ignored, bus_ready still issued.
- Pad outputs update on the same edge the write completes, with no extra latency.
- Input path:
  - 2-flop synchronizer s1→s2, reset to 0; a third flop s3 holds the previous s2.
  - IN reads s2, so an input change is visible after 2–3 cycles.
  - rise[i] = s2[i] & ~s3[i].
- Interrupts:
  - Each cycle, STAT[i] is set if rise[i] & EN[i].
  - A W1C write clears the bits written as 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Clearing EN does not clear STAT.
  - irq = registered |STAT, so it asserts one cycle after STAT sets.
- Reset mid-transaction: bus_ready drops immediately and the request is abandoned; the master re-issues it.
- Pulldown and pullup both set is passed through unchanged; the padframe resolves it.

Decomposition:
- Shared package openframe_gpio_pkg holds the register offset localparams (REG_OUT_LO … REG_IRQ_STAT_HI), the reset-value constants, and the function-index enumeration for the nine pad-control registers.
- One sub-module, gpio_in_sync: per-bit 2-flop synchronizer plus edge flop, parameterized by NPADS, outputting s2 and rise.

Test Plan:
- Reset: hold resetb=0, then release → gpio_ie=0xFFF_FFFFFFFF, all other pad outputs 0, irq=0; reading 0x10 returns 0xFFFFFFFF and 0x14 returns 0x00000FFF.
- Write 0x08=0x0000_00FF with wstrb=4'b0001, then 0x0C=0xFFFF_FFFF → gpio_oe[7:0]=1 and gpio_oe[43:32]=1 on the ready edge; reading 0x0C returns 0x00000FFF; bus_ready is exactly 1 cycle after valid.
- Byte strobe: write 0x00=0xAABBCCDD with wstrb=4'b0100 from an OUT_LO of 0 → OUT_LO reads 0x00BB0000.
- Interrupt: IRQ_EN_HI=0x001; drive gpio_in[32] 0→1 → STAT_HI bit0 set within 4 cycles and irq=1; write 0x5C=0x1 → irq=0; a rising edge on pad 33 (not enabled) leaves irq=0.
- Set-vs-clear collision: schedule a W1C of pad 0 on the same cycle as rise[0] with EN set → STAT bit stays 1 and irq stays 1.
- Unmapped address: read 0x7C → bus_rdata=0 with ready; write 0x60 → no register changes; assert resetb low during a pending request → bus_ready=0 and all registers at reset values.

Source files
------------

// File: rtl/openframe_gpio_ctrl_pkg.sv
// Shared definitions for the openframe GPIO pad controller: register offsets,
// reset constants and the pad-control function index.
package openframe_gpio_pkg;

  localparam int unsigned REG_OUT_LO       = 32'h00;
  localparam int unsigned REG_OUT_HI       = 32'h04;
  localparam int unsigned REG_OE_LO        = 32'h08;
  localparam int unsigned REG_OE_HI        = 32'h0C;
  localparam int unsigned REG_IE_LO        = 32'h10;
  localparam int unsigned REG_IE_HI        = 32'h14;
  localparam int unsigned REG_SCHMITT_LO   = 32'h18;
  localparam int unsigned REG_SCHMITT_HI   = 32'h1C;
  localparam int unsigned REG_SLEW_LO      = 32'h20;
  localparam int unsigned REG_SLEW_HI      = 32'h24;
  localparam int unsigned REG_PULLUP_LO    = 32'h28;
  localparam int unsigned REG_PULLUP_HI    = 32'h2C;
  localparam int unsigned REG_PULLDOWN_LO  = 32'h30;
  localparam int unsigned REG_PULLDOWN_HI  = 32'h34;
  localparam int unsigned REG_DRIVE0_LO    = 32'h38;
  localparam int unsigned REG_DRIVE0_HI    = 32'h3C;
  localparam int unsigned REG_DRIVE1_LO    = 32'h40;
  localparam int unsigned REG_DRIVE1_HI    = 32'h44;
  localparam int unsigned REG_IN_LO        = 32'h48;
  localparam int unsigned REG_IN_HI        = 32'h4C;
  localparam int unsigned REG_IRQ_EN_LO    = 32'h50;
  localparam int unsigned REG_IRQ_EN_HI    = 32'h54;
  localparam int unsigned REG_IRQ_STAT_LO  = 32'h58;
  localparam int unsigned REG_IRQ_STAT_HI  = 32'h5C;

  localparam logic [63:0] RST_IE    = '1;
  localparam logic [63:0] RST_OTHER = '0;

  typedef enum logic [3:0] {
    FN_OUT      = 4'd0,
    FN_OE       = 4'd1,
    FN_IE       = 4'd2,
    FN_SCHMITT  = 4'd3,
    FN_SLEW     = 4'd4,
    FN_PULLUP   = 4'd5,
    FN_PULLDOWN = 4'd6,
    FN_DRIVE0   = 4'd7,
    FN_DRIVE1   = 4'd8
  } pad_fn_e;

  localparam int unsigned NUM_FN = 9;

  function automatic logic [31:0] strobe_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/openframe_gpio_ctrl_in_sync.sv
// Pad input synchronizer: two-flop s1->s2 plus s3 holding the previous s2
// for rising-edge detection.
module gpio_in_sync #(
  parameter int unsigned NPADS = 44
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [NPADS-1:0] gpio_in,
  output logic [NPADS-1:0] s2,
  output logic [NPADS-1:0] rise
);

  logic [NPADS-1:0] s1;
  logic [NPADS-1:0] s3;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= gpio_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/openframe_gpio_ctrl.sv
// Memory-mapped GPIO pad controller on the picosoc iomem bus: per-pad control
// registers, synchronized input readback and rising-edge level interrupt.
module openframe_gpio_ctrl
  import openframe_gpio_pkg::*;
#(
  parameter int unsigned NPADS  = 44,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              bus_valid,
  output logic              bus_ready,
  input  logic [3:0]        bus_wstrb,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic [NPADS-1:0]  gpio_in,
  output logic [NPADS-1:0]  gpio_out,
  output logic [NPADS-1:0]  gpio_oe,
  output logic [NPADS-1:0]  gpio_ie,
  output logic [NPADS-1:0]  gpio_schmitt,
  output logic [NPADS-1:0]  gpio_slew,
  output logic [NPADS-1:0]  gpio_pullup,
  output logic [NPADS-1:0]  gpio_pulldown,
  output logic [NPADS-1:0]  gpio_drive0,
  output logic [NPADS-1:0]  gpio_drive1,
  output logic              irq
);

  logic                req;
  logic                wr_en;
  int unsigned         off;
  int unsigned         base;
  int unsigned         fn_sel;
  logic                hi;
  logic                sel_ctrl, sel_in, sel_en, sel_stat;
  logic [NPADS-1:0]    wmask, wdata_pad, stat_clr;
  logic [NPADS-1:0]    sync_s2, sync_rise;
  logic [NPADS-1:0]    irq_en, irq_stat;
  logic [NPADS-1:0]    ctrl_q [NUM_FN];
  logic [NUM_FN:0][63:0] ctrl_acc;
  logic [63:0]         rd_full;
  logic [31:0]         rd_word;

  // A request is accepted only on the cycle ready is low, giving one-cycle latency
  assign req    = bus_valid & ~bus_ready;
  assign wr_en  = req & (bus_wstrb != 4'b0000);
  assign off    = 32'(bus_addr) & ~32'd3;
  assign base   = off & ~32'd4;
  assign fn_sel = (base - REG_OUT_LO) >> 3;
  assign hi     = bus_addr[2];

  assign sel_ctrl = (base <= REG_DRIVE1_LO);
  assign sel_in   = (base == REG_IN_LO);
  assign sel_en   = (base == REG_IRQ_EN_LO);
  assign sel_stat = (base == REG_IRQ_STAT_LO);

  // HI words map onto pads 63:32; the cast drops lanes above NPADS-1
  assign wmask     = NPADS'(hi ? {strobe_mask(bus_wstrb), 32'h0} : {32'h0, strobe_mask(bus_wstrb)});
  assign wdata_pad = NPADS'({bus_wdata, bus_wdata});
  assign stat_clr  = (wr_en && sel_stat) ? (wmask & wdata_pad) : '0;

  gpio_in_sync #(.NPADS(NPADS)) u_in_sync (
    .clk     (clk),
    .resetb  (resetb),
    .gpio_in (gpio_in),
    .s2      (sync_s2),
    .rise    (sync_rise)
  );

  assign ctrl_acc[0] = '0;

  for (genvar f = 0; f < NUM_FN; f++) begin : g_fn
    localparam logic [63:0] RST_FULL = (f == int'(FN_IE)) ? RST_IE : RST_OTHER;

    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        ctrl_q[f] <= RST_FULL[NPADS-1:0];
      end else if (wr_en && sel_ctrl && (fn_sel == f)) begin
        ctrl_q[f] <= (ctrl_q[f] & ~wmask) | (wdata_pad & wmask);
      end
    end

    assign ctrl_acc[f+1] = ctrl_acc[f] | ((fn_sel == f) ? 64'(ctrl_q[f]) : 64'h0);
  end

  always_comb begin
    rd_full = '0;
    if (sel_ctrl) begin
      rd_full = ctrl_acc[NUM_FN];
    end else if (sel_in) begin
      rd_full = 64'(sync_s2);
    end else if (sel_en) begin
      rd_full = 64'(irq_en);
    end else if (sel_stat) begin
      rd_full = 64'(irq_stat);
    end
    rd_word = hi ? rd_full[63:32] : rd_full[31:0];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
      irq_en    <= '0;
      irq_stat  <= '0;
      irq       <= 1'b0;
    end else begin
      bus_ready <= req;
      bus_rdata <= req ? rd_word : '0;
      if (wr_en && sel_en) begin
        irq_en <= (irq_en & ~wmask) | (wdata_pad & wmask);
      end
      // Set is OR-ed after the clear so a same-cycle edge wins over W1C
      irq_stat <= (irq_stat & ~stat_clr) | (sync_rise & irq_en);
      irq      <= |irq_stat;
    end
  end

  assign gpio_out      = ctrl_q[FN_OUT];
  assign gpio_oe       = ctrl_q[FN_OE];
  assign gpio_ie       = ctrl_q[FN_IE];
  assign gpio_schmitt  = ctrl_q[FN_SCHMITT];
  assign gpio_slew     = ctrl_q[FN_SLEW];
  assign gpio_pullup   = ctrl_q[FN_PULLUP];
  assign gpio_pulldown = ctrl_q[FN_PULLDOWN];
  assign gpio_drive0   = ctrl_q[FN_DRIVE0];
  assign gpio_drive1   = ctrl_q[FN_DRIVE1];

endmodule

// File: tb/tb_openframe_gpio_ctrl.sv
// Scoreboard bench for openframe_gpio_ctrl: directed bus transactions push
// expected read data; a negedge monitor pops and compares on bus_ready.
module tb_openframe_gpio_ctrl;

  localparam int unsigned NPADS  = 44;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              bus_valid = 1'b0;
  logic              bus_ready;
  logic [3:0]        bus_wstrb = '0;
  logic [ADDR_W-1:0] bus_addr = '0;
  logic [31:0]       bus_wdata = '0;
  logic [31:0]       bus_rdata;
  logic [NPADS-1:0]  gpio_in = '0;
  logic [NPADS-1:0]  gpio_out, gpio_oe, gpio_ie, gpio_schmitt, gpio_slew;
  logic [NPADS-1:0]  gpio_pullup, gpio_pulldown, gpio_drive0, gpio_drive1;
  logic              irq;

  openframe_gpio_ctrl #(.NPADS(NPADS), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .bus_valid     (bus_valid),
    .bus_ready     (bus_ready),
    .bus_wstrb     (bus_wstrb),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .gpio_oe       (gpio_oe),
    .gpio_ie       (gpio_ie),
    .gpio_schmitt  (gpio_schmitt),
    .gpio_slew     (gpio_slew),
    .gpio_pullup   (gpio_pullup),
    .gpio_pulldown (gpio_pulldown),
    .gpio_drive0   (gpio_drive0),
    .gpio_drive1   (gpio_drive1),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] data;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic ready_prev = 1'b0;

  always @(negedge clk) begin
    if (bus_ready) begin
      n_checks++;
      if (ready_prev) begin
        n_fail++;
        $display("FAIL ready_pulse: got bus_ready=1 on two consecutive cycles, required a single-cycle pulse");
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got bus_ready=1 with no request outstanding, required 0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.chk) begin
          n_checks++;
          if (bus_rdata !== e.data) begin
            n_fail++;
            $display("FAIL %s: got rdata=%h required %h", e.nm, bus_rdata, e.data);
          end
        end
      end
    end else if (resetb && (bus_rdata !== 32'h0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL rdata_idle: got rdata=%h while bus_ready=0, required 00000000", bus_rdata);
    end
    ready_prev = bus_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [7:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                          input bit chk, input logic [31:0] exp, input string nm);
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 4 && bus_ready; i++) @(negedge clk);
    e.chk  = chk;
    e.data = exp;
    e.nm   = nm;
    exp_q.push_back(e);
    bus_valid = 1'b1;
    bus_addr  = addr;
    bus_wstrb = wstrb;
    bus_wdata = wdata;
    @(posedge clk);
    #1;
    n_checks++;
    if (!bus_ready) begin
      n_fail++;
      $display("FAIL %s_latency: got bus_ready=0 one cycle after valid, required 1", nm);
      for (int i = 0; i < 8 && !bus_ready; i++) begin
        @(posedge clk);
        #1;
      end
    end
    bus_valid = 1'b0;
    bus_wstrb = '0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string nm);
    bus_xfer(addr, 4'b0000, 32'h0, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [3:0] wstrb, input logic [31:0] data, input string nm);
    bus_xfer(addr, wstrb, data, 1'b0, 32'h0, nm);
  endtask

  task automatic check_pads(input string nm,
                            input logic [63:0] e_out, input logic [63:0] e_oe, input logic [63:0] e_ie,
                            input logic [63:0] e_sch, input logic [63:0] e_slew, input logic [63:0] e_pu,
                            input logic [63:0] e_pd, input logic [63:0] e_d0, input logic [63:0] e_d1);
    chk64({nm, "_out"},      64'(gpio_out),      e_out);
    chk64({nm, "_oe"},       64'(gpio_oe),       e_oe);
    chk64({nm, "_ie"},       64'(gpio_ie),       e_ie);
    chk64({nm, "_schmitt"},  64'(gpio_schmitt),  e_sch);
    chk64({nm, "_slew"},     64'(gpio_slew),     e_slew);
    chk64({nm, "_pullup"},   64'(gpio_pullup),   e_pu);
    chk64({nm, "_pulldown"}, 64'(gpio_pulldown), e_pd);
    chk64({nm, "_drive0"},   64'(gpio_drive0),   e_d0);
    chk64({nm, "_drive1"},   64'(gpio_drive1),   e_d1);
  endtask

  localparam logic [63:0] IE_ALL = 64'h0000_0FFF_FFFF_FFFF;

  initial begin
    // Reset
    cycles(3);
    check_pads("rst", 64'h0, 64'h0, IE_ALL, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk64("rst_irq", 64'(irq), 64'h0);
    chk64("rst_ready", 64'(bus_ready), 64'h0);
    chk64("rst_rdata", 64'(bus_rdata), 64'h0);
    @(negedge clk);
    resetb = 1'b1;
    rd(8'h10, 32'hFFFF_FFFF, "rd_ie_lo_rst");
    rd(8'h14, 32'h0000_0FFF, "rd_ie_hi_rst");

    // OE with byte strobe and HI upper-bit masking; pads update on the ready edge
    wr(8'h08, 4'b0001, 32'h0000_00FF, "wr_oe_lo");
    wr(8'h0C, 4'b1111, 32'hFFFF_FFFF, "wr_oe_hi");
    chk64("oe_same_edge", 64'(gpio_oe), 64'h0000_0FFF_0000_00FF);
    rd(8'h0C, 32'h0000_0FFF, "rd_oe_hi");
    rd(8'h08, 32'h0000_00FF, "rd_oe_lo");

    // Single byte lane
    wr(8'h00, 4'b0100, 32'hAABB_CCDD, "wr_out_lo");
    chk64("out_byte2", 64'(gpio_out), 64'h0000_0000_00BB_0000);
    rd(8'h00, 32'h00BB_0000, "rd_out_lo");
    rd(8'h04, 32'h0000_0000, "rd_out_hi");

    // Remaining pad controls, including pullup+pulldown together
    wr(8'h1C, 4'b1111, 32'hFFFF_F123, "wr_schmitt_hi");
    wr(8'h20, 4'b1111, 32'h8000_0001, "wr_slew_lo");
    wr(8'h28, 4'b1111, 32'h0000_0005, "wr_pullup_lo");
    wr(8'h30, 4'b1111, 32'h0000_0005, "wr_pulldown_lo");
    wr(8'h38, 4'b1111, 32'h1234_5678, "wr_drive0_lo");
    wr(8'h44, 4'b1111, 32'h0000_0800, "wr_drive1_hi");
    wr(8'h10, 4'b0011, 32'h0000_0000, "wr_ie_lo");
    check_pads("cfg", 64'h00BB_0000, 64'h0000_0FFF_0000_00FF, 64'h0000_0FFF_FFFF_0000,
               64'h0000_0123_0000_0000, 64'h8000_0001, 64'h5, 64'h5, 64'h1234_5678,
               64'h0000_0800_0000_0000);
    rd(8'h1C, 32'h0000_0123, "rd_schmitt_hi");
    rd(8'h44, 32'h0000_0800, "rd_drive1_hi");
    rd(8'h30, 32'h0000_0005, "rd_pulldown_lo");

    // Synchronized input readback, read-only
    gpio_in = 44'hABC_1234_5678;
    cycles(3);
    rd(8'h48, 32'h1234_5678, "rd_in_lo");
    rd(8'h4C, 32'h0000_0ABC, "rd_in_hi");
    wr(8'h48, 4'b1111, 32'h0000_0000, "wr_in_lo");
    rd(8'h48, 32'h1234_5678, "rd_in_lo_ro");
    gpio_in = '0;
    cycles(4);
    chk64("irq_no_en", 64'(irq), 64'h0);
    rd(8'h58, 32'h0000_0000, "rd_stat_lo_no_en");

    // Enabled rising edge on pad 32, then W1C
    wr(8'h54, 4'b1111, 32'h0000_0001, "wr_en_hi");
    rd(8'h54, 32'h0000_0001, "rd_en_hi");
    gpio_in[32] = 1'b1;
    for (int i = 0; i < 6 && !irq; i++) cycles(1);
    chk64("irq_pad32", 64'(irq), 64'h1);
    rd(8'h5C, 32'h0000_0001, "rd_stat_hi_set");
    rd(8'h58, 32'h0000_0000, "rd_stat_lo_clean");
    wr(8'h5C, 4'b1111, 32'h0000_0001, "w1c_stat_hi");
    cycles(2);
    chk64("irq_cleared", 64'(irq), 64'h0);
    rd(8'h5C, 32'h0000_0000, "rd_stat_hi_clr");
    gpio_in[33] = 1'b1;
    cycles(6);
    chk64("irq_pad33_masked", 64'(irq), 64'h0);
    rd(8'h5C, 32'h0000_0000, "rd_stat_hi_masked");

    // W1C lands on the same edge that pad 0's rise sets STAT: set must win
    wr(8'h50, 4'b1111, 32'h0000_0001, "wr_en_lo");
    gpio_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    wr(8'h58, 4'b1111, 32'h0000_0001, "w1c_collide");
    cycles(2);
    chk64("irq_collide", 64'(irq), 64'h1);
    rd(8'h58, 32'h0000_0001, "rd_stat_collide");
    wr(8'h50, 4'b1111, 32'h0000_0000, "wr_en_lo_off");
    rd(8'h58, 32'h0000_0001, "rd_stat_en_off");
    chk64("irq_en_off", 64'(irq), 64'h1);
    wr(8'h58, 4'b1111, 32'h0000_0001, "w1c_stat_lo");
    cycles(2);
    chk64("irq_final_clr", 64'(irq), 64'h0);
    rd(8'h58, 32'h0000_0000, "rd_stat_lo_clr");

    // Unmapped offsets
    rd(8'h7C, 32'h0000_0000, "rd_unmapped_7c");
    rd(8'h60, 32'h0000_0000, "rd_unmapped_60");
    wr(8'h60, 4'b1111, 32'hFFFF_FFFF, "wr_unmapped_60");
    check_pads("unmapped", 64'h00BB_0000, 64'h0000_0FFF_0000_00FF, 64'h0000_0FFF_FFFF_0000,
               64'h0000_0123_0000_0000, 64'h8000_0001, 64'h5, 64'h5, 64'h1234_5678,
               64'h0000_0800_0000_0000);
    rd(8'h00, 32'h00BB_0000, "rd_out_after_unmapped");
    rd(8'h54, 32'h0000_0001, "rd_en_hi_after_unmapped");

    // Reset while a response is being presented
    @(negedge clk);
    bus_valid = 1'b1;
    bus_addr  = 8'h00;
    bus_wstrb = 4'b1111;
    bus_wdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    resetb = 1'b0;
    #1;
    chk64("midrst_ready", 64'(bus_ready), 64'h0);
    bus_valid = 1'b0;
    bus_wstrb = '0;
    check_pads("midrst", 64'h0, 64'h0, IE_ALL, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    chk64("midrst_irq", 64'(irq), 64'h0);
    @(negedge clk);
    resetb = 1'b1;
    rd(8'h00, 32'h0000_0000, "rd_out_lo_postrst");
    rd(8'h10, 32'hFFFF_FFFF, "rd_ie_lo_postrst");
    rd(8'h54, 32'h0000_0000, "rd_en_hi_postrst");
    rd(8'h1C, 32'h0000_0000, "rd_schmitt_hi_postrst");

    cycles(3);
    chk64("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
